data_mem_mp: RTL and testbench

//  Parametrised multi-read-port register file for the datapath. Successor to the fixed 4x16, 3-read-port store.

---
 rtl/data_mem_mp.sv | 134 +++++++++++++
 tb/tb_data_mem_mp.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_mp.sv
// Multi-read-port register file with optional write-to-read bypass, a
// cycle-by-cycle clear sweep and dropped-write reporting.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset_n    asynchronous active-low reset
//   r_addr     packed read addresses, port i = [i*ADDR_W +: ADDR_W]
//   r_data     packed read data, port i = [i*DATA_W +: DATA_W] (combinational)
//   w_flag     write enable
//   w_add      write address
//   w_data     write data
//   clear_req  start a clear sweep (level sampled at the rising edge)
//   busy       clear sweep in progress
//   w_drop     one-cycle pulse: the write of the previous cycle was discarded
//   debug      contents of entry 0, never bypassed
module data_mem_mp #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned NUM_RD = 3,
  parameter int unsigned BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_RD*ADDR_W-1:0] r_addr,
  output logic [NUM_RD*DATA_W-1:0] r_data,
  input  logic                     w_flag,
  input  logic [ADDR_W-1:0]        w_add,
  input  logic [DATA_W-1:0]        w_data,
  input  logic                     clear_req,
  output logic                     busy,
  output logic                     w_drop,
  output logic [DATA_W-1:0]        debug
);

  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   DepthL  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

  typedef enum logic {StIdle, StClear} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                sweep_en;
  logic                w_drop_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic w_in_range;
  logic w_accept;
  logic w_discard;

  assign w_in_range = {1'b0, w_add} < DepthL;
  assign w_accept   = w_flag && (state_q == StIdle) && w_in_range;
  assign w_discard  = w_flag && !w_accept;

  // FSM next state and sweep counter.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sweep_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clear_req) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        sweep_en = 1'b1;
        if (cnt_q == LastIdx) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      w_drop_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      w_drop_q <= w_discard;
    end
  end

  // Writes are only accepted in idle and the sweep only runs in clear,
  // so the two updates never target the array in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        mem_q[k] <= '0;
      end
    end else begin
      if (w_accept) begin
        mem_q[w_add] <= w_data;
      end
      if (sweep_en) begin
        mem_q[cnt_q] <= '0;
      end
    end
  end

  for (genvar i = 0; i < int'(NUM_RD); i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              ra_in_range;
    logic [DATA_W-1:0] rd;

    assign ra          = r_addr[i*ADDR_W +: ADDR_W];
    assign ra_in_range = {1'b0, ra} < DepthL;

    // w_accept already excludes the sweep, so no bypass while busy.
    always_comb begin
      rd = '0;
      if ((BYPASS != 0) && w_accept && (w_add == ra)) begin
        rd = w_data;
      end else if (ra_in_range) begin
        rd = mem_q[ra];
      end
    end

    assign r_data[i*DATA_W +: DATA_W] = rd;
  end

  assign busy   = (state_q == StClear);
  assign w_drop = w_drop_q;
  assign debug  = mem_q[0];

endmodule

// File: tb/tb_data_mem_mp.sv
module tb_data_mem_mp;

  localparam int DW = 16;
  localparam int AW = 2;
  localparam int NR = 3;

  logic            clk;
  logic            reset_n;
  logic [NR*AW-1:0] r_addr;
  logic [NR*DW-1:0] r_data;
  logic [NR*DW-1:0] r_data_nb;
  logic            w_flag;
  logic [AW-1:0]   w_add;
  logic [DW-1:0]   w_data;
  logic            clear_req;
  logic            busy, busy_nb;
  logic            w_drop, w_drop_nb;
  logic [DW-1:0]   debug, debug_nb;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] sb_q[$];

  data_mem_mp #(.DATA_W(DW), .DEPTH(4), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1)) dut (
    .clk(clk), .reset_n(reset_n), .r_addr(r_addr), .r_data(r_data),
    .w_flag(w_flag), .w_add(w_add), .w_data(w_data), .clear_req(clear_req),
    .busy(busy), .w_drop(w_drop), .debug(debug)
  );

  data_mem_mp #(.DATA_W(DW), .DEPTH(4), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(0)) dut_nb (
    .clk(clk), .reset_n(reset_n), .r_addr(r_addr), .r_data(r_data_nb),
    .w_flag(w_flag), .w_add(w_add), .w_data(w_data), .clear_req(clear_req),
    .busy(busy_nb), .w_drop(w_drop_nb), .debug(debug_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input logic [DW-1:0] v);
    sb_q.push_back(v);
  endtask

  task automatic sb_pop_check(input string tag, input logic [DW-1:0] obs);
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got %h expected <scoreboard empty>", tag, obs);
    end else begin
      check(tag, obs, sb_q.pop_front());
    end
  endtask

  // Push three expected port values, then compare against the DUT ports.
  task automatic rd_check(input string tag, input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                          input logic [DW-1:0] e2);
    sb_push(e0);
    sb_push(e1);
    sb_push(e2);
    #1;
    for (int i = 0; i < NR; i++) begin
      sb_pop_check($sformatf("%s_p%0d", tag, i), r_data[i*DW +: DW]);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    w_flag = 1'b1;
    w_add  = a;
    w_data = d;
    cyc();
    w_flag = 1'b0;
  endtask

  task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [AW-1:0] a2);
    r_addr = {a2, a1, a0};
  endtask

  initial begin
    int n;
    reset_n   = 1'b0;
    r_addr    = '0;
    w_flag    = 1'b0;
    w_add     = '0;
    w_data    = '0;
    clear_req = 1'b0;
    #1;
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_wdrop", {15'd0, w_drop}, 16'd0);
    check("rst_debug", debug, 16'd0);
    cyc();
    reset_n = 1'b1;

    // 1: preload, then async reset between edges.
    wr(2'd1, 16'h0011);
    wr(2'd2, 16'h0022);
    wr(2'd3, 16'h0033);
    set_ra(2'd1, 2'd2, 2'd3);
    rd_check("t1_pre", 16'h0011, 16'h0022, 16'h0033);
    reset_n = 1'b0;
    rd_check("t1_rst", 16'h0000, 16'h0000, 16'h0000);
    check("t1_debug", debug, 16'd0);
    check("t1_busy", {15'd0, busy}, 16'd0);
    #1;
    reset_n = 1'b1;
    cyc();

    // 2: write/read with and without bypass.
    wr(2'd2, 16'h0022);
    set_ra(2'd2, 2'd2, 2'd2);
    w_flag = 1'b1;
    w_add  = 2'd2;
    w_data = 16'hA5A5;
    rd_check("t2_byp", 16'hA5A5, 16'hA5A5, 16'hA5A5);
    sb_push(16'h0022);
    sb_pop_check("t2_nobyp_old", r_data_nb[DW-1:0]);
    cyc();
    w_flag = 1'b0;
    rd_check("t2_after", 16'hA5A5, 16'hA5A5, 16'hA5A5);
    sb_push(16'hA5A5);
    sb_pop_check("t2_nobyp_new", r_data_nb[2*DW-1:DW]);
    check("t2_wdrop", {15'd0, w_drop}, 16'd0);

    // 3: clear sweep, entry k reads 0 once k+1 edges have passed since busy rose.
    wr(2'd0, 16'd1);
    wr(2'd1, 16'd2);
    wr(2'd2, 16'd3);
    wr(2'd3, 16'd4);
    set_ra(2'd1, 2'd2, 2'd3);
    clear_req = 1'b1;
    #1;
    check("t3_busy_pre", {15'd0, busy}, 16'd0);
    cyc();
    clear_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check($sformatf("t3_busy_c%0d", c), {15'd0, busy}, 16'd1);
      check($sformatf("t3_e0_c%0d", c), debug, (c > 0) ? 16'd0 : 16'd1);
      rd_check($sformatf("t3_c%0d", c), (c > 1) ? 16'd0 : 16'd2, (c > 2) ? 16'd0 : 16'd3,
               16'd4);
      cyc();
    end
    check("t3_busy_end", {15'd0, busy}, 16'd0);
    check("t3_e0_end", debug, 16'd0);
    rd_check("t3_end", 16'd0, 16'd0, 16'd0);

    // 4: write during sweep is dropped and not bypassed.
    wr(2'd3, 16'h7777);
    clear_req = 1'b1;
    cyc();
    clear_req = 1'b0;
    set_ra(2'd3, 2'd3, 2'd3);
    w_flag = 1'b1;
    w_add  = 2'd3;
    w_data = 16'h1234;
    rd_check("t4_nobyp", 16'h7777, 16'h7777, 16'h7777);
    check("t4_wdrop_pre", {15'd0, w_drop}, 16'd0);
    cyc();
    w_flag = 1'b0;
    #1;
    check("t4_wdrop", {15'd0, w_drop}, 16'd1);
    rd_check("t4_kept", 16'h7777, 16'h7777, 16'h7777);
    cyc();
    #1;
    check("t4_wdrop_off", {15'd0, w_drop}, 16'd0);
    cyc();
    cyc();
    check("t4_busy_end", {15'd0, busy}, 16'd0);
    rd_check("t4_swept", 16'd0, 16'd0, 16'd0);

    // 5: clear request and write to entry 0 in the same idle cycle.
    set_ra(2'd0, 2'd1, 2'd2);
    clear_req = 1'b1;
    w_flag    = 1'b1;
    w_add     = 2'd0;
    w_data    = 16'hBEEF;
    rd_check("t5_byp", 16'hBEEF, 16'd0, 16'd0);
    check("t5_debug_nobyp", debug, 16'd0);
    cyc();
    clear_req = 1'b0;
    w_flag    = 1'b0;
    #1;
    check("t5_debug_beef", debug, 16'hBEEF);
    check("t5_busy", {15'd0, busy}, 16'd1);
    check("t5_wdrop", {15'd0, w_drop}, 16'd0);
    cyc();
    check("t5_debug_swept", debug, 16'd0);
    n = 0;
    while (busy && n < 8) begin
      cyc();
      n++;
    end
    check("t5_busy_len", 16'(n), 16'd3);

    // 6: async reset in the middle of a sweep.
    wr(2'd1, 16'h0101);
    wr(2'd2, 16'h0202);
    wr(2'd3, 16'h0303);
    wr(2'd0, 16'h0404);
    set_ra(2'd1, 2'd2, 2'd3);
    clear_req = 1'b1;
    cyc();
    clear_req = 1'b0;
    cyc();
    check("t6_busy_mid", {15'd0, busy}, 16'd1);
    reset_n = 1'b0;
    #1;
    check("t6_busy_rst", {15'd0, busy}, 16'd0);
    check("t6_debug_rst", debug, 16'd0);
    rd_check("t6_rst", 16'd0, 16'd0, 16'd0);
    reset_n = 1'b1;
    cyc();
    wr(2'd2, 16'h5A5A);
    rd_check("t6_wr", 16'd0, 16'h5A5A, 16'd0);
    check("t6_busy_after", {15'd0, busy}, 16'd0);
    check("t6_wdrop_after", {15'd0, w_drop}, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Backstop so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
